user_key_ctrl: RTL
==================

USER_KEY_CTRL -- requirements
Module: user_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 8, consecutive stable cycles needed to accept a key level change; legal range 1..65535.
REQ-002 SHALL have port clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rstn  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port user_key  input  8  raw board keys, asynchronous, active-low (1 = released).
REQ-005 SHALL have port addr  input  2  word select for CPU bus: 0 STATE, 1 EVENT, 2 CTRL, 3 reserved.
REQ-006 SHALL have port we  input  1  bus write strobe, one-cycle qualified.
REQ-007 SHALL have port wdata  input  32  bus write data.
REQ-008 SHALL have port rdata  output  32  bus read data, combinational from addr.
REQ-009 SHALL have port irq  output  1  level interrupt request to CPU.

Function
REQ-010 SHALL pass each user_key bit through a 2-flop synchronizer; synced value lags raw by 2 edges.
REQ-011 SHALL keep per-bit 16-bit counter: +1 each cycle synced != debounced, cleared to 0 when equal.
REQ-012 SHALL, when counter == DEBOUNCE_CYC-1 and synced still != debounced, load debounced <= synced and clear counter on that edge.
REQ-013 Raw change held stable SHALL reach debounced exactly 2+DEBOUNCE_CYC edges later; glitches shorter than DEBOUNCE_CYC synced cycles SHALL be ignored.
REQ-014 STATE register SHALL read {24'b0, ~debounced} (1 = pressed); read-only, writes ignored.
REQ-015 EVENT[7:0] SHALL set bit i on the edge debounced[i] goes 1->0 (press); release sets nothing; upper bits read 0.
REQ-016 EVENT write SHALL be write-1-to-clear on wdata[7:0]; same-cycle press event and W1C on same bit SHALL leave bit set.
REQ-017 CTRL[7:0] SHALL be per-key interrupt mask (1 = enabled), CTRL[8] global irq enable; read/write; bits 31:9 read 0.
REQ-018 irq SHALL be registered: irq <= CTRL[8] & |(EVENT & CTRL[7:0]), one-edge latency after EVENT/CTRL update.
REQ-019 addr 3 SHALL read 0; writes to addr 3 SHALL have no effect.
REQ-020 Multiple keys SHALL debounce independently; simultaneous presses set all corresponding EVENT bits in one edge.

Reset
REQ-021 On clk_in edge with sys_rstn == 0: synchronizer flops and debounced = 8'hFF, counters = 0, EVENT = 0, CTRL = 0, irq = 0.
REQ-022 Reset mid-debounce SHALL abort the count; no EVENT bit set for a press held through reset until it is re-qualified after release of reset (full 2+DEBOUNCE_CYC from reset deassertion, since debounced restarts at FF).
REQ-023 rdata SHALL reflect reset register values during reset.

Structure
REQ-024 Shared package SHALL hold register word indices (STATE=0, EVENT=1, CTRL=2), key count 8, counter width 16, CTRL bit positions.
REQ-025 SHALL instantiate sub-module key_debounce (synchronizer + counter + debounced flop, one bit) 8 times; bus/register logic stays in user_key_ctrl.

Verification
REQ-026 Reset 300 cycles, all keys released -> rdata STATE = 0, EVENT = 0, CTRL = 0, irq = 0.
REQ-027 CTRL write 0x101; user_key = 8'hFE for 20 cycles -> STATE bit0 = 1 exactly 10 edges after change, EVENT = 0x01, irq = 1 one edge later; W1C 0x01 -> EVENT = 0, irq = 0 next edge.
REQ-028 user_key bit3 low for 5 cycles (DEBOUNCE_CYC 8) -> STATE, EVENT, irq unchanged.
REQ-029 W1C EVENT = 0x01 on same edge as new key0 press qualifies -> EVENT bit0 remains 1, irq stays 1.
REQ-030 Keys 8'h7E pressed together, CTRL = 0x080 -> EVENT = 0x81, irq = 0 (global disabled); then CTRL = 0x180 -> irq = 1.
REQ-031 sys_rstn low at cycle 5 of a key0 press held low throughout -> after reset release, EVENT bit0 sets exactly 2+DEBOUNCE_CYC edges after sys_rstn returns high.

Source files
------------

// File: rtl/user_key_ctrl_pkg.sv
// Shared definitions for the user key controller: register word map,
// key count, debounce counter width and CTRL bit layout.
package user_key_ctrl_pkg;

  localparam int KEY_NUM = 8;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_EVENT = 2'd1,
    REG_CTRL  = 2'd2,
    REG_RSVD  = 2'd3
  } reg_idx_e;

  localparam int CTRL_MASK_LSB = 0;
  localparam int CTRL_GIE_BIT  = 8;
  localparam int CTRL_W        = 9;

endpackage

// File: rtl/user_key_ctrl_key_debounce.sv
// One-bit key debouncer: 2-flop synchronizer, stability counter, debounced flop.
// Latency 2+DEBOUNCE_CYC edges from raw change to key_deb; no backpressure.
module key_debounce
  import user_key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic key_raw,
  output logic key_deb,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  // hit marks the edge on which the synced level is accepted
  assign hit   = (sync_b != key_deb) && (cnt == CNT_LAST);
  assign press = hit && !sync_b;

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      sync_a  <= 1'b1;
      sync_b  <= 1'b1;
      key_deb <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
      if (sync_b == key_deb) begin
        cnt <= '0;
      end else if (hit) begin
        key_deb <= sync_b;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_key_ctrl.sv
// Board key controller: 8 debounced keys, STATE/EVENT(W1C)/CTRL registers, level irq.
// irq registered one edge after EVENT/CTRL change; bus has no backpressure.
module user_key_ctrl
  import user_key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic                clk_in,
  input  logic                sys_rstn,
  input  logic [KEY_NUM-1:0]  user_key,
  input  logic [1:0]          addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                irq
);

  logic [KEY_NUM-1:0] key_deb;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] event_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [KEY_NUM-1:0] w1c_mask;
  logic               unused_wdata;
  reg_idx_e           sel;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk_in  (clk_in),
      .sys_rstn(sys_rstn),
      .key_raw (user_key[i]),
      .key_deb (key_deb[i]),
      .press   (key_press[i])
    );
  end

  assign sel          = reg_idx_e'(addr);
  assign w1c_mask     = (we && sel == REG_EVENT) ? wdata[KEY_NUM-1:0] : '0;
  assign unused_wdata = ^wdata[31:CTRL_W];

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      event_q <= '0;
      ctrl_q  <= '0;
      irq     <= 1'b0;
    end else begin
      // a press on the same edge as its clear wins
      event_q <= (event_q & ~w1c_mask) | key_press;
      if (we && sel == REG_CTRL) begin
        ctrl_q <= wdata[CTRL_W-1:0];
      end
      irq <= ctrl_q[CTRL_GIE_BIT] &
             |(event_q & ctrl_q[CTRL_MASK_LSB +: KEY_NUM]);
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATE: rdata[KEY_NUM-1:0] = ~key_deb;
      REG_EVENT: rdata[KEY_NUM-1:0] = event_q;
      REG_CTRL:  rdata[CTRL_W-1:0]  = ctrl_q;
      default:   rdata = '0;
    endcase
  end

endmodule
